pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/mips_pkg.sv | 6 +
 rtl/fetch_target_calc.sv | 17 +
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch FSM state encoding, redirect kind codes and reset PC default
package mips_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;
  typedef enum logic [1:0] {RK_NONE = 2'b00, RK_BRANCH = 2'b01, RK_JUMP = 2'b10, RK_JR = 2'b11} redirect_kind_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_target_calc.sv
// fetch_target_calc: redirect target from kind/base/offset/jump_target/jr_addr, plus jr misalign flag
module fetch_target_calc
  import mips_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [31:0] base,
  input  logic [15:0] offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] target,
  output logic        misalign
);
  assign target = kind == RK_BRANCH ? base + {{14{offset[15]}}, offset, 2'b00}
                : kind == RK_JUMP   ? {base[31:28], jump_target, 2'b00}
                :                     {jr_addr[31:2], 2'b00};
  assign misalign = kind == RK_JR && |jr_addr[1:0];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding imem fetch FSM (clk, rst_n, imem req/rsp, stall, redirect_*) driving IF/ID regs if_*, with hold buffer and jr misalign pulse
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_base,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        misalign
);
  fetch_state_t state, state_n;
  logic [31:0] pc, target, hold_instr, hold_pc4;
  logic        hold_valid, misalign_c, redir, hs, rsp_take;
  fetch_target_calc u_calc (
    .kind(redirect_kind),
    .base(redirect_base),
    .offset(branch_offset),
    .jump_target(jump_target),
    .jr_addr(jr_addr),
    .target(target),
    .misalign(misalign_c)
  );
  assign redir          = redirect_valid && redirect_kind != RK_NONE;
  assign imem_req_valid = state == REQ && !hold_valid;
  assign imem_addr      = pc;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp_take       = state == WAIT && imem_rsp_valid && !redir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = hs ? (redir ? DRAIN : WAIT) : REQ;
      WAIT:    state_n = imem_rsp_valid ? REQ : (redir ? DRAIN : WAIT);
      DRAIN:   state_n = imem_rsp_valid ? REQ : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc4     <= '0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc4   <= '0;
      misalign   <= 1'b0;
    end else begin
      misalign <= redir && misalign_c;
      if (redir) begin
        pc         <= target;
        if_valid   <= 1'b0;
        hold_valid <= 1'b0;
      end else begin
        if (rsp_take) pc <= pc + 32'd4;
        if (rsp_take && (!if_valid || !stall)) begin
          if_valid <= 1'b1;
          if_instr <= imem_rsp_data;
          if_pc4   <= pc + 32'd4;
        end else if (if_valid && !stall) begin
          if_valid   <= hold_valid;
          hold_valid <= 1'b0;
          if (hold_valid) begin
            if_instr <= hold_instr;
            if_pc4   <= hold_pc4;
          end
        end
        if (rsp_take && if_valid && stall) begin
          hold_valid <= 1'b1;
          hold_instr <= imem_rsp_data;
          hold_pc4   <= pc + 32'd4;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed-vector self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_kind = 2'b00;
  logic [31:0] redirect_base = '0;
  logic [15:0] branch_offset = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_addr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        misalign;
  int          n_vec = 0;
  int          n_bad = 0;
  pc_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind),
    .redirect_base(redirect_base),
    .branch_offset(branch_offset),
    .jump_target(jump_target),
    .jr_addr(jr_addr),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc4(if_pc4),
    .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_addr, addr);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask
  task automatic redirect(input logic [1:0] k, input logic [31:0] b, input logic [15:0] o, input logic [25:0] j, input logic [31:0] r);
    redirect_valid = 1'b1;
    redirect_kind  = k;
    redirect_base  = b;
    branch_offset  = o;
    jump_target    = j;
    jr_addr        = r;
  endtask
  initial begin
    #2;
    check("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst if_valid", {31'd0, if_valid}, 32'd0);
    check("rst addr", imem_addr, 32'h0);
    check("rst misalign", {31'd0, misalign}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch_one(32'h0, 32'h1111_0000);
    check("f0 valid", {31'd0, if_valid}, 32'd1);
    check("f0 instr", if_instr, 32'h1111_0000);
    check("f0 pc4", if_pc4, 32'h4);
    fetch_one(32'h4, 32'h1111_0004);
    check("f1 pc4", if_pc4, 32'h8);
    fetch_one(32'h8, 32'h1111_0008);
    check("f2 pc4", if_pc4, 32'hC);
    check("f2 valid", {31'd0, if_valid}, 32'd1);
    stall = 1'b1;
    check("st req_addr", imem_addr, 32'hC);
    tick();
    check("st1 instr", if_instr, 32'h1111_0008);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_000C;
    tick();
    imem_rsp_valid = 1'b0;
    check("st2 instr", if_instr, 32'h1111_0008);
    check("st2 no req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check("st3 instr", if_instr, 32'h1111_0008);
    check("st3 pc4", if_pc4, 32'hC);
    check("st3 no req", {31'd0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    tick();
    check("unst instr", if_instr, 32'h1111_000C);
    check("unst pc4", if_pc4, 32'h10);
    check("unst valid", {31'd0, if_valid}, 32'd1);
    check("unst addr", imem_addr, 32'h10);
    stall = 1'b1;
    tick();
    redirect(2'b01, 32'h100, 16'hFFFF, 26'h0, 32'h0);
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    check("br if_valid", {31'd0, if_valid}, 32'd0);
    check("br drain no req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("br discard", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0FC, 32'h2222_00FC);
    check("br instr", if_instr, 32'h2222_00FC);
    check("br pc4", if_pc4, 32'h100);
    imem_req_ready = 1'b0;
    redirect(2'b10, 32'hA000_0010, 16'h0, 26'h0000040, 32'h0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    check("jmp addr", imem_addr, 32'hA000_0100);
    check("jmp if_valid", {31'd0, if_valid}, 32'd0);
    check("jmp req_valid", {31'd0, imem_req_valid}, 32'd1);
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_0203);
    tick();
    redirect_valid = 1'b0;
    check("jr misalign", {31'd0, misalign}, 32'd1);
    check("jr drain", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check("jr misalign once", {31'd0, misalign}, 32'd0);
    imem_rsp_valid = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    check("jr addr", imem_addr, 32'h0000_0200);
    check("jr req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();
    redirect(2'b01, 32'h1000, 16'h0004, 26'h0, 32'h0);
    tick();
    redirect(2'b10, 32'h1000_0000, 16'h0, 26'h10, 32'h0);
    tick();
    redirect_valid = 1'b0;
    check("dr2 no req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    check("dr2 addr", imem_addr, 32'h1000_0040);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAAD_F00D;
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_0300);
    tick();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    check("rr addr", imem_addr, 32'h300);
    check("rr req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rr if_valid", {31'd0, if_valid}, 32'd0);
    check("rr misalign", {31'd0, misalign}, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mrst addr", imem_addr, 32'h0);
    check("mrst pc4", if_pc4, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    check("post rst if_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0, 32'h3333_0000);
    check("post rst instr", if_instr, 32'h3333_0000);
    check("post rst pc4", if_pc4, 32'h4);
    imem_req_ready = 1'b0;
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    fetch_one(32'hFFFF_FFFC, 32'h4444_FFFC);
    check("wrap instr", if_instr, 32'h4444_FFFC);
    check("wrap pc4", if_pc4, 32'h0);
    check("wrap addr", imem_addr, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
